// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi211_bist.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__aoi211_bist
//
// Built-in self-test driver/checker for the aoi211 standard cell. The block
// drives the cell inputs A1/A2/B/C through all 16 input combinations, holds
// each pattern for SETTLE_CYCLES cycles, then spends one CHECK cycle and
// compares the returned ZN against the golden function
//   ZN = ~((A1 & A2) | B | C)
// on the edge that ends CHECK. The run reports pass/fail, a saturating
// mismatch count and the index of the first failing pattern.
//
// Parameters:
//   SETTLE_CYCLES  cycles each pattern is held before its check cycle (>= 1)
//   ERR_W          width of the saturating mismatch counter
//
// Ports:
//   CLK       in   rising-edge clock
//   RST       in   synchronous active-high reset
//   START     in   single-cycle run request, honoured only in IDLE or DONE
//   ZN        in   output of the cell under test
//   A1,A2,B,C out  cell inputs = pattern index bits 3,2,1,0 (0 when quiescent)
//   BUSY      out  run in progress
//   DONE      out  run complete, held until next START or RST
//   PASS      out  DONE and no mismatches
//   ERR_CNT   out  mismatch count, saturates at all-ones
//   FAIL_VLD  out  sticky: at least one mismatch this run
//   FAIL_IDX  out  pattern index of the first mismatch (valid with FAIL_VLD)
//
// Optional feature macro: GF180MCU_FD_SC_MCU7T5V0__AOI211_BIST_XCHK_EN
//   Defined:   compare uses case-inequality, so X/Z on ZN is a mismatch
//              (meant for power-aware simulation of the cell model).
//   Undefined: compare uses logical inequality; only hard 0/1 errors count.
//              This is the synthesizable form.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__aoi211_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             B,
  output logic             C,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_VLD,
  output logic [3:0]       FAIL_IDX
);

  // The settle counter counts down from SETTLE_CYCLES-1 to 0, so it only
  // needs enough bits to hold SETTLE_CYCLES-1 (minimum one bit).
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [3:0]       LAST_IDX    = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state;
  logic [3:0]       idx;
  logic [CNT_W-1:0] settle_cnt;

  logic             exp_zn;
  logic             mismatch;
  logic [ERR_W-1:0] err_cnt_nxt;

  // Golden response for the pattern currently on the cell inputs, the
  // mismatch decision, and the saturating next value of the error counter.
  always_comb begin
    exp_zn      = ~((idx[3] & idx[2]) | idx[1] | idx[0]);
`ifdef GF180MCU_FD_SC_MCU7T5V0__AOI211_BIST_XCHK_EN
    mismatch    = (ZN !== exp_zn);
`else
    mismatch    = (ZN != exp_zn);
`endif
    err_cnt_nxt = ERR_CNT;
    if (mismatch && (ERR_CNT != ERR_MAX)) begin
      err_cnt_nxt = ERR_CNT + ERR_W'(1);
    end
  end

  // Sequencer. All outputs are registered here; the pattern outputs are
  // loaded on the same edge that updates idx so the cell sees the new
  // pattern for the full SETTLE + CHECK window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      idx        <= 4'd0;
      settle_cnt <= '0;
      A1         <= 1'b0;
      A2         <= 1'b0;
      B          <= 1'b0;
      C          <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_CNT    <= '0;
      FAIL_VLD   <= 1'b0;
      FAIL_IDX   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state      <= ST_SETTLE;
            idx        <= 4'd0;
            settle_cnt <= SETTLE_LOAD;
            {A1, A2, B, C} <= 4'd0;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VLD   <= 1'b0;
            FAIL_IDX   <= 4'd0;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end

        ST_CHECK: begin
          ERR_CNT <= err_cnt_nxt;
          if (mismatch && !FAIL_VLD) begin
            FAIL_IDX <= idx;
            FAIL_VLD <= 1'b1;
          end
          // Pattern 15 is terminal; idx never wraps within a run.
          if (idx != LAST_IDX) begin
            idx            <= idx + 4'd1;
            {A1, A2, B, C} <= idx + 4'd1;
            settle_cnt     <= SETTLE_LOAD;
            state          <= ST_SETTLE;
          end else begin
            state          <= ST_DONE;
            {A1, A2, B, C} <= 4'd0;
            BUSY           <= 1'b0;
            DONE           <= 1'b1;
            PASS           <= (err_cnt_nxt == '0);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__aoi211_bist.sv
// ---------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu7t5v0__aoi211_bist
//
// Directed bench for the aoi211 BIST. The main instance (ERR_W=5) sees a ZN
// that is either an ideal aoi211 model or stuck at 0/1, selected by zn_mode.
// A second instance with ERR_W=3 always sees ZN stuck at 1 to exercise
// counter saturation.
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__aoi211_bist;

  logic       clk;
  logic       rst;
  logic       start;
  logic       zn;
  logic       a1, a2, b, c;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic       fail_vld;
  logic [3:0] fail_idx;

  logic       start3;
  logic       a1_3, a2_3, b_3, c_3;
  logic       busy3, done3, pass3;
  logic [2:0] err_cnt3;
  logic       fail_vld3;
  logic [3:0] fail_idx3;

  int zn_mode;
  int checkCount;
  int errorCount;
  int cycles;

  gf180mcu_fd_sc_mcu7t5v0__aoi211_bist #(.SETTLE_CYCLES(2), .ERR_W(5)) dut (
    .CLK(clk), .RST(rst), .START(start), .ZN(zn),
    .A1(a1), .A2(a2), .B(b), .C(c),
    .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_CNT(err_cnt), .FAIL_VLD(fail_vld), .FAIL_IDX(fail_idx)
  );

  gf180mcu_fd_sc_mcu7t5v0__aoi211_bist #(.SETTLE_CYCLES(2), .ERR_W(3)) dut3 (
    .CLK(clk), .RST(rst), .START(start3), .ZN(1'b1),
    .A1(a1_3), .A2(a2_3), .B(b_3), .C(c_3),
    .BUSY(busy3), .DONE(done3), .PASS(pass3),
    .ERR_CNT(err_cnt3), .FAIL_VLD(fail_vld3), .FAIL_IDX(fail_idx3)
  );

  // Cell model: 0 = ideal aoi211, 1 = stuck-at-0, 2 = stuck-at-1.
  assign zn = (zn_mode == 1) ? 1'b0 :
              (zn_mode == 2) ? 1'b1 :
              ~((a1 & a2) | b | c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Pulse START so it is sampled on the next rising edge (e0), then count
  // edges after e0 until DONE. Optionally checks the pattern/BUSY each
  // cycle and injects ignored START pulses at the given cycle numbers.
  task automatic applyStimulus(input bit checkPattern, input int pulseA,
                               input int pulseB, output int nCycles);
    int n;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (checkPattern) begin
      checkOutput("pat_e0", {28'd0, a1, a2, b, c}, 32'd0);
      checkOutput("busy_e0", {31'd0, busy}, 32'd1);
    end
    n = 0;
    nCycles = -1;
    while (n < 200) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) begin
        nCycles = n;
        break;
      end
      if (checkPattern) begin
        checkOutput($sformatf("pat_n%0d", n), {28'd0, a1, a2, b, c}, n / 3);
      end
      if (n == pulseA || n == pulseB) start = 1'b1;
    end
    checkOutput("done_timeout", {31'd0, nCycles != -1}, 32'd1);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    zn_mode    = 0;
    rst        = 1'b1;
    start      = 1'b0;
    start3     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_pass", {31'd0, pass}, 32'd0);
    checkOutput("rst_pat", {28'd0, a1, a2, b, c}, 32'd0);
    checkOutput("rst_err", {27'd0, err_cnt}, 32'd0);
    checkOutput("rst_fvld", {31'd0, fail_vld}, 32'd0);
    checkOutput("rst_fidx", {28'd0, fail_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ideal cell: full pattern walk, DONE 48 cycles after START sampled.
    applyStimulus(1'b1, -1, -1, cycles);
    checkOutput("ideal_lat", cycles, 32'd48);
    checkOutput("ideal_pass", {31'd0, pass}, 32'd1);
    checkOutput("ideal_err", {27'd0, err_cnt}, 32'd0);
    checkOutput("ideal_fvld", {31'd0, fail_vld}, 32'd0);
    checkOutput("ideal_busy", {31'd0, busy}, 32'd0);
    checkOutput("ideal_pat", {28'd0, a1, a2, b, c}, 32'd0);

    // Stuck-at-0: golden ZN is 1 only at idx 0, 4, 8.
    zn_mode = 1;
    applyStimulus(1'b0, -1, -1, cycles);
    checkOutput("sa0_lat", cycles, 32'd48);
    checkOutput("sa0_err", {27'd0, err_cnt}, 32'd3);
    checkOutput("sa0_fidx", {28'd0, fail_idx}, 32'd0);
    checkOutput("sa0_fvld", {31'd0, fail_vld}, 32'd1);
    checkOutput("sa0_pass", {31'd0, pass}, 32'd0);

    // Restart from DONE with ERR_CNT=3: results clear on the start edge.
    zn_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("rs_err", {27'd0, err_cnt}, 32'd0);
    checkOutput("rs_fvld", {31'd0, fail_vld}, 32'd0);
    checkOutput("rs_busy", {31'd0, busy}, 32'd1);
    checkOutput("rs_done", {31'd0, done}, 32'd0);
    cycles = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = n;
        break;
      end
    end
    checkOutput("rs_lat", cycles, 32'd48);
    checkOutput("rs_pass", {31'd0, pass}, 32'd1);

    // START pulses at cycles 10 and 20 are ignored while busy.
    applyStimulus(1'b0, 10, 20, cycles);
    checkOutput("ign_lat", cycles, 32'd48);
    checkOutput("ign_pass", {31'd0, pass}, 32'd1);

    // Reset mid-run while pattern 5 is applied (stuck-at-0, ERR_CNT=2 then).
    zn_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    checkOutput("mid_pat", {28'd0, a1, a2, b, c}, 32'd5);
    checkOutput("mid_err", {27'd0, err_cnt}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mrst_pat", {28'd0, a1, a2, b, c}, 32'd0);
    checkOutput("mrst_err", {27'd0, err_cnt}, 32'd0);
    checkOutput("mrst_fvld", {31'd0, fail_vld}, 32'd0);
    zn_mode = 0;
    applyStimulus(1'b0, -1, -1, cycles);
    checkOutput("mrst_lat", cycles, 32'd48);
    checkOutput("mrst_pass", {31'd0, pass}, 32'd1);

    // Stuck-at-1 on the 3-bit counter instance: 13 mismatches saturate at 7.
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    cycles = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        cycles = n;
        break;
      end
    end
    checkOutput("sa1_lat", cycles, 32'd48);
    checkOutput("sa1_err", {29'd0, err_cnt3}, 32'd7);
    checkOutput("sa1_fidx", {28'd0, fail_idx3}, 32'd1);
    checkOutput("sa1_fvld", {31'd0, fail_vld3}, 32'd1);
    checkOutput("sa1_pass", {31'd0, pass3}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
